// File: rtl/cla_iter_alu_if.sv
// Operand/result handshake bundle for cla_iter_alu.
// The ALU connects through the slave modport; the producer/consumer side uses master.
`timescale 1ns/1ps
interface cla_iter_alu_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/cla_iter_alu.sv
// Iterative carry-lookahead ALU: resolves GPC 4-bit groups per cycle and chains the
// group carry through a register, so a WIDTH-bit operation takes WIDTH/(4*GPC) cycles.
`timescale 1ns/1ps
module cla_iter_alu #(
  parameter int WIDTH = 16,
  parameter int GPC   = 1
) (
  input logic         clk,
  input logic         rst,
  cla_iter_alu_if.slave bus
);
  localparam int SW = 4 * GPC;
  localparam int N  = WIDTH / SW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, result_q, result_next;
  logic [2:0]       op_r;
  logic             cin_r, carry_r, cout_q, ovf_q, zero_q;

  logic             arith, sub, last, c_in;
  logic [SW-1:0]    a_s, b_s, g, p, slice_res;
  logic [SW:0]      c;
  logic [GPC-1:0]   grp_g, grp_p;
  logic [GPC:0]     grp_c;

  // Two-level sum-of-products carry: ci*P[0..n-1] + sum_k g[k]*P[k+1..n-1], no ripple.
  function automatic logic carry_sop(input logic [SW-1:0] gv, input logic [SW-1:0] pv,
                                     input logic ci, input int n);
    logic acc, term;
    term = ci;
    for (int m = 0; m < n; m++) term = term & pv[m];
    acc = term;
    for (int k = 0; k < n; k++) begin
      term = gv[k];
      for (int m = k + 1; m < n; m++) term = term & pv[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  assign arith = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign sub   = (op_r == OP_SUB);
  assign last  = (cnt == CW'(N - 1));
  assign c_in  = arith & ((cnt == '0) ? cin_r : carry_r);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    a_s       = a_r[SW-1:0];
    b_s       = sub ? ~b_r[SW-1:0] : b_r[SW-1:0];
    g         = arith ? (a_s & b_s) : '0;
    p         = arith ? (a_s | b_s) : '0;
    grp_g     = '0;
    grp_p     = '0;
    grp_c     = '0;
    c         = '0;
    slice_res = '0;

    for (int j = 0; j < GPC; j++) begin
      grp_g[j] = carry_sop(SW'(g[4*j +: 4]), SW'(p[4*j +: 4]), 1'b0, 4);
      grp_p[j] = &p[4*j +: 4];
    end
    for (int j = 0; j <= GPC; j++)
      grp_c[j] = carry_sop(SW'(grp_g), SW'(grp_p), c_in, j);
    for (int j = 0; j < GPC; j++)
      for (int i = 0; i < 4; i++)
        c[4*j + i] = carry_sop(SW'(g[4*j +: 4]), SW'(p[4*j +: 4]), grp_c[j], i);
    c[SW] = grp_c[GPC];

    unique case (op_r)
      OP_ADD, OP_SUB: slice_res = a_s ^ b_s ^ c[SW-1:0];
      OP_AND:         slice_res = a_r[SW-1:0] & b_r[SW-1:0];
      OP_OR:          slice_res = a_r[SW-1:0] | b_r[SW-1:0];
      OP_XOR:         slice_res = a_r[SW-1:0] ^ b_r[SW-1:0];
      default:        slice_res = '0;
    endcase

    // Slices enter at the top; after N cycles slice 0 has reached bit 0.
    result_next = (result_q >> SW) | (WIDTH'(slice_res) << (WIDTH - SW));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= '0;
      cin_r    <= 1'b0;
      carry_r  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          a_r      <= bus.a;
          b_r      <= bus.b;
          op_r     <= bus.op;
          cin_r    <= bus.cin;
          cnt      <= '0;
          carry_r  <= 1'b0;
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
          zero_q   <= 1'b0;
        end
        RUN: begin
          a_r      <= a_r >> SW;
          b_r      <= b_r >> SW;
          carry_r  <= c[SW];
          result_q <= result_next;
          cnt      <= cnt + 1'b1;
          if (last) begin
            cout_q <= c[SW];
            ovf_q  <= c[SW] ^ c[SW-1];
            zero_q <= (result_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_iter_alu.sv
// Bench for cla_iter_alu: a 16-bit/GPC=1 and a 32-bit/GPC=2 instance driven with the same
// operands, compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_cla_iter_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, cin, out_ready;
  logic [31:0] a_drv, b_drv;
  logic [2:0]  op;

  always #5 clk = ~clk;

  cla_iter_alu_if #(.WIDTH(16)) bus16 ();
  cla_iter_alu_if #(.WIDTH(32)) bus32 ();

  assign bus16.in_valid  = in_valid;
  assign bus16.a         = a_drv[15:0];
  assign bus16.b         = b_drv[15:0];
  assign bus16.cin       = cin;
  assign bus16.op        = op;
  assign bus16.out_ready = out_ready;
  assign bus32.in_valid  = in_valid;
  assign bus32.a         = a_drv;
  assign bus32.b         = b_drv;
  assign bus32.cin       = cin;
  assign bus32.op        = op;
  assign bus32.out_ready = out_ready;

  cla_iter_alu #(.WIDTH(16), .GPC(1)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  cla_iter_alu #(.WIDTH(32), .GPC(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  logic [34:0] got16, got32;
  assign got16 = {16'h0, bus16.result, bus16.cout, bus16.ovf, bus16.zero};
  assign got32 = {bus32.result, bus32.cout, bus32.ovf, bus32.zero};

  int checks = 0;
  int failures = 0;
  time t_accept;

  // Directed vectors with hand-computed 16-bit expectations {result, cout, ovf, zero}.
  localparam logic [31:0] VA [9] = '{32'h1234, 32'hFFFF, 32'h8000, 32'h0000, 32'hF0F0,
                                     32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'h1234};
  localparam logic [31:0] VB [9] = '{32'h0FFF, 32'h0001, 32'h0001, 32'h0001, 32'hFF00,
                                     32'hFF00, 32'hFF00, 32'h00000001, 32'h5678};
  localparam logic        VC [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [2:0]  VO [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5};
  localparam logic [18:0] VE [9] = '{{16'h2233, 3'b000}, {16'h0000, 3'b101},
                                     {16'h7FFF, 3'b110}, {16'hFFFF, 3'b000},
                                     {16'hF000, 3'b000}, {16'hFFF0, 3'b000},
                                     {16'h0FF0, 3'b000}, {16'h0000, 3'b101},
                                     {16'h0000, 3'b001}};

  // Reference: w-bit add of a + b' + cin, signed overflow from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic [2:0] o, input int w);
    logic [32:0] s;
    logic [31:0] mask, bb, r;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a  = a & mask;
    b  = b & mask;
    bb = (o == 3'd1) ? (~b & mask) : b;
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (o)
      3'd0, 3'd1: begin
        s  = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
        r  = s[31:0] & mask;
        co = s[w];
        ov = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = '0;
    endcase
    return {r, co, ov, (r == 32'd0)};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic [2:0] o);
    @(negedge clk);
    a_drv    = a;
    b_drv    = b;
    cin      = ci;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    t_accept = $time;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a_drv = 32'h1111; b_drv = 32'h2222; cin = 1'b0; op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    checks++;
    if (got16 !== 35'd0 || got32 !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got16=%h got32=%h expected 0", got16, got32);
    end
    checks++;
    if ({bus16.in_ready, bus16.out_valid, bus32.in_ready, bus32.out_valid} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_handshake got=%b expected 1010",
               {bus16.in_ready, bus16.out_valid, bus32.in_ready, bus32.out_valid});
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus16.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_accept in_ready16=%b in_ready32=%b expected 1",
               bus16.in_ready, bus32.in_ready);
    end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 9; i++) begin
      start_op(VA[i], VB[i], VC[i], VO[i]);
      wait_done(lat);
      checks++;
      if (lat != 4 || bus32.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL directed_latency[%0d] got=%0d v32=%b expected 4", i, lat, bus32.out_valid);
      end
      checks++;
      if (got16[18:0] !== VE[i]) begin
        failures++;
        $display("FAIL directed16[%0d] got=%h expected=%h", i, got16[18:0], VE[i]);
      end
      checks++;
      if (got32 !== model(VA[i], VB[i], VC[i], VO[i], 32)) begin
        failures++;
        $display("FAIL directed32[%0d] got=%h expected=%h", i, got32,
                 model(VA[i], VB[i], VC[i], VO[i], 32));
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [34:0] exp16;
    exp16 = model(32'hA5A5, 32'h5A5A, 1'b0, 3'd0, 16);
    start_op(32'hA5A5, 32'h5A5A, 1'b0, 3'd0);
    wait_done(lat);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_drv    = $urandom;
      b_drv    = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if (got16 !== exp16 || bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold got=%h v=%b r=%b expected=%h v=1 r=0",
                 got16, bus16.out_valid, bus16.in_ready, exp16);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release v=%b r=%b expected v=0 r=1",
               bus16.out_valid, bus16.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int  lat;
    time prev;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      a_drv = $urandom;
      b_drv = $urandom;
      start_op(a_drv, b_drv, 1'b1, 3'(i % 2));
      if (i > 0) begin
        checks++;
        if (t_accept - prev != 60) begin
          failures++;
          $display("FAIL b2b_spacing[%0d] got=%0t expected=60", i, t_accept - prev);
        end
      end
      prev = t_accept;
      wait_done(lat);
      checks++;
      if (lat != 4 || got16 !== model(a_drv, b_drv, 1'b1, 3'(i % 2), 16)) begin
        failures++;
        $display("FAIL b2b_result[%0d] lat=%0d got=%h expected=%h", i, lat, got16,
                 model(a_drv, b_drv, 1'b1, 3'(i % 2), 16));
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_single_done[%0d] v=%b r=%b expected v=0 r=1", i,
                 bus16.out_valid, bus16.in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] ra, rb;
    logic        rc;
    logic [2:0]  ro;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      ro = 3'($urandom_range(0, 7));
      start_op(ra, rb, rc, ro);
      wait_done(lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      checks++;
      if (got16 !== model(ra, rb, rc, ro, 16)) begin
        failures++;
        $display("FAIL random16[%0d] op=%0d got=%h expected=%h", i, ro, got16,
                 model(ra, rb, rc, ro, 16));
      end
      checks++;
      if (got32 !== model(ra, rb, rc, ro, 32)) begin
        failures++;
        $display("FAIL random32[%0d] op=%0d got=%h expected=%h", i, ro, got32,
                 model(ra, rb, rc, ro, 32));
      end
      release_out();
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    logic seen;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (got16 !== 35'd0 || got32 !== 35'd0 || bus16.in_ready !== 1'b1 ||
        bus16.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got16=%h got32=%h r=%b v=%b expected 0/0/1/0",
               got16, got32, bus16.in_ready, bus16.out_valid);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | bus16.out_valid | bus32.out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrun_discard out_valid_seen=%b expected 0", seen);
    end
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd0);
    wait_done(lat);
    checks++;
    if (lat != 4 || got32 !== {32'h0, 3'b101}) begin
      failures++;
      $display("FAIL rerun32 lat=%0d got=%h expected lat=4 %h", lat, got32, {32'h0, 3'b101});
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_iter_alu.md
# cla_iter_alu

Parametrised, iterative carry-lookahead ALU that extends the team's 4-bit lookahead adder slice to an arbitrary word width. It processes GPC 4-bit groups per clock, chaining the group carry between cycles, and supports arithmetic and logic modes. Operands enter and results leave through valid/ready handshakes. It sits between the operand register file and the result/flag writeback stage of the ALU datapath.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4*GPC.
- GPC, 1, 4-bit groups resolved per cycle; N = WIDTH/(4*GPC) compute cycles.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operand bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; used only by ADD/SUB.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, others reserved.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  ALU result.
- cout  out  1  carry out of the MSB group.
- ovf  out  1  signed overflow.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid=1: latch a, b, cin and op; clear cnt and the result register; go to RUN.
- RUN:
  - Each cycle, take group slice cnt (bits [4*GPC*cnt +: 4*GPC]).
  - Per bit: p=a|b', g=a&b', where b'=~b for SUB and b'=b otherwise.
  - Carries inside each 4-bit group use lookahead: c[i+1] = g[i] | p[i]&c[i], expanded as sum of products, no ripple.
  - Across the GPC groups of one cycle, use group P/G lookahead.
  - Carry into slice 0 is cin. Every later slice takes the carry registered from the previous cycle.
  - When cnt==N-1, go to DONE.
- Arithmetic result bit = a^b'^c.
- Logic ops: carry chain gated to 0 (mode gating). Bit = a&b, a|b or a^b.
- Reserved op: result 0, cout 0, ovf 0.
- cout:
  - ADD/SUB: carry out of bit WIDTH-1.
  - Logic ops: 0.
- SUB computes a + ~b + cin. Plain subtraction requires cin=1; cout=1 means no borrow.
- ovf = c[WIDTH]^c[WIDTH-1] for ADD/SUB; 0 otherwise.
- zero is computed from the full final result. It is valid in DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready=1, go to IDLE.
  - in_ready=0 in DONE; the next bundle is accepted no earlier than the cycle after the DONE→IDLE transition.
- Inputs a, b, op and cin are don't-care outside the IDLE accept cycle. The latched copies are used throughout RUN.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, state IDLE.
- Accept handshake completes at edge k. out_valid rises after edge k+N+... precisely:
  - State is RUN for cycles k+1..k+N.
  - DONE is entered at edge k+N, so out_valid is high from that edge onward.
  - Latency is N+1 edges from accept to the first possible result handshake.
- Throughput is one operation per N+2 cycles: accept, N RUN cycles, at least one DONE cycle, with IDLE re-entry merged into the next accept.
- out_ready held low: remain in DONE indefinitely with all outputs constant. No data loss.
- out_ready high on DONE entry: one DONE cycle, then IDLE.
- rst asserted in any state, including mid-RUN: next edge goes to IDLE, all outputs take their reset values, and the in-flight operation is discarded with no out_valid.
- rst and in_valid high together: reset wins, nothing is accepted.

## Test plan
- WIDTH=16, GPC=1: ADD a=0x1234, b=0x0FFF, cin=0 → result 0x2233, cout=0, ovf=0, zero=0; out_valid high exactly 4 edges after accept.
- ADD a=0xFFFF, b=0x0001, cin=0 → result 0x0000, cout=1, zero=1, ovf=0. This checks carry crossing all four group boundaries.
- SUB a=0x8000, b=0x0001, cin=1 → result 0x7FFF, cout=1, ovf=1. Also SUB a=0x0000, b=0x0001, cin=1 → 0xFFFF, cout=0, ovf=0.
- AND a=0xF0F0, b=0xFF00 → 0xF000; OR → 0xFFF0; XOR → 0x0FF0. cout=0 and ovf=0 for all three, even with cin=1.
- Backpressure: hold out_ready low for 3 cycles in DONE → result stable, in_ready=0, in_valid ignored. Release → one handshake, IDLE next cycle.
- Reset mid-RUN at cnt=2 → IDLE next edge, out_valid never asserts, outputs return to 0. Rerun with WIDTH=32, GPC=2 on 0xFFFFFFFF+1 → result 0, cout=1, latency 4 edges.
